// File: rtl/imem_loader_if.sv
// Byte-stream, IMem write-port and status bundle of the instruction-memory loader.
// The slave modport is the loader's view; the master modport is the source/consumer side.
interface imem_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        imem_wea;
  logic [31:0] imem_addra;
  logic [31:0] imem_dina;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  modport slave (
    input  start, in_valid, in_byte,
    output in_ready, imem_wea, imem_addra, imem_dina,
    output core_reset, busy, done, error
  );

  modport master (
    output start, in_valid, in_byte,
    input  in_ready, imem_wea, imem_addra, imem_dina,
    input  core_reset, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a checksummed big-endian byte stream into 32-bit words,
// writes them to consecutive IMem addresses and releases the core only on success.
module imem_loader #(
  parameter int SIZE   = 32,
  parameter int ADDR_W = 9
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [SIZE-1:0]     word_q, word_d;
  logic [7:0]          csum_q, csum_d;
  logic                in_ready_q, in_ready_d;
  logic                wea_q, wea_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [SIZE-1:0]     dina_q, dina_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                core_reset_q, core_reset_d;

  logic                accept;
  logic [15:0]         n_hdr;
  logic [SIZE-1:0]     word_shifted;
  logic [16:0]         idx_inc;

  assign accept       = bus.in_valid & in_ready_q;
  assign n_hdr        = {count_q[15:8], bus.in_byte};
  assign word_shifted = {word_q[SIZE-9:0], bus.in_byte};
  // Widened so the last-word test works for N == DEPTH without index overflow.
  assign idx_inc      = 17'(idx_q) + 17'd1;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    wea_d      = 1'b0;
    addra_d    = addra_q;
    dina_d     = dina_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_d    = HDR_HI;
          count_d    = '0;
          idx_d      = '0;
          byte_cnt_d = '0;
          word_d     = '0;
          csum_d     = '0;
        end
      end
      HDR_HI: begin
        if (accept) begin
          count_d[15:8] = bus.in_byte;
          state_d       = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_d = n_hdr;
          if (n_hdr > 16'(DEPTH)) begin
            state_d = ERR;
          end else if (n_hdr == 16'd0) begin
            state_d = CHK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d     = word_shifted;
          csum_d     = csum_q ^ bus.in_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
            wea_d   = 1'b1;
            addra_d = idx_q;
            dina_d  = word_shifted;
          end
        end
      end
      WRITE: begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = (idx_inc == {1'b0, count_q}) ? CHK : DATA;
      end
      CHK: begin
        if (accept) begin
          state_d = (bus.in_byte == csum_q) ? DONE : ERR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered decodes of the next state so they line up with state_q.
    in_ready_d   = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                   (state_d == DATA)   || (state_d == CHK);
    busy_d       = (state_d != IDLE) && (state_d != DONE) && (state_d != ERR);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERR);
    core_reset_d = (state_d != DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      in_ready_q   <= 1'b0;
      wea_q        <= 1'b0;
      addra_q      <= '0;
      dina_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      in_ready_q   <= in_ready_d;
      wea_q        <= wea_d;
      addra_q      <= addra_d;
      dina_q       <= dina_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_wea   = wea_q;
  assign bus.imem_addra = 32'(addra_q);
  assign bus.imem_dina  = dina_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.core_reset = core_reset_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed stream table, timing/reset sequences and
// randomized images checked against a queue-based model of the stream format.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader #(.SIZE(32), .ADDR_W(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          wea_cyc[$];
  int          wea_viol = 0;
  int          done_cyc = 0;
  logic        wea_prev = 1'b0;
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      wea_prev  <= 1'b0;
      done_prev <= 1'b0;
    end else begin
      if (bus.imem_wea) begin
        got_addr.push_back(bus.imem_addra);
        got_data.push_back(bus.imem_dina);
        wea_cyc.push_back(cyc);
      end
      if (bus.imem_wea && wea_prev) wea_viol <= wea_viol + 1;
      if (bus.done && !done_prev) done_cyc <= cyc;
      wea_prev  <= bus.imem_wea;
      done_prev <= bus.done;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stimulus and expectation queues filled before each load
  logic [7:0]  stim_q[$];
  logic [31:0] exp_data_q[$];
  int          last_start;

  task automatic do_start();
    @(negedge clk);
    bus.start  = 1'b1;
    last_start = cyc;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tmo;
    tmo          = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (!bus.in_ready && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 100) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.in_byte = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic run_load(input string name, input int gap, input bit rnd_gap,
                          input bit exp_done, input bit exp_err);
    int base;
    int n_got;
    int n_cmp;
    base = got_addr.size();
    do_start();
    for (int i = 0; i < stim_q.size(); i++) begin
      send_byte(stim_q[i], rnd_gap ? int'($urandom_range(gap, 0)) : gap);
    end
    repeat (2) @(negedge clk);
    n_got = got_addr.size() - base;
    check($sformatf("%s_nwrites", name), 32'(n_got), 32'(exp_data_q.size()));
    n_cmp = (n_got < exp_data_q.size()) ? n_got : exp_data_q.size();
    for (int i = 0; i < n_cmp; i++) begin
      check($sformatf("%s_addr%0d", name, i), got_addr[base+i], 32'(i));
      check($sformatf("%s_data%0d", name, i), got_data[base+i], exp_data_q[i]);
    end
    check($sformatf("%s_done", name), 32'(bus.done), 32'(exp_done));
    check($sformatf("%s_error", name), 32'(bus.error), 32'(exp_err));
    check($sformatf("%s_core_reset", name), 32'(bus.core_reset), 32'(!exp_done));
    check($sformatf("%s_busy", name), 32'(bus.busy), 32'd0);
    check($sformatf("%s_in_ready", name), 32'(bus.in_ready), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check($sformatf("%s_in_ready", name), 32'(bus.in_ready), 32'd0);
    check($sformatf("%s_wea", name), 32'(bus.imem_wea), 32'd0);
    check($sformatf("%s_addra", name), bus.imem_addra, 32'd0);
    check($sformatf("%s_dina", name), bus.imem_dina, 32'd0);
    check($sformatf("%s_busy", name), 32'(bus.busy), 32'd0);
    check($sformatf("%s_done", name), 32'(bus.done), 32'd0);
    check($sformatf("%s_error", name), 32'(bus.error), 32'd0);
    check($sformatf("%s_core_reset", name), 32'(bus.core_reset), 32'd1);
  endtask

  // Builds stimulus and expected words for an N-word image from first principles.
  task automatic model_image(input int n, input bit corrupt);
    logic [7:0]  cs;
    logic [31:0] w;
    stim_q.delete();
    exp_data_q.delete();
    stim_q.push_back(8'(n >> 8));
    stim_q.push_back(8'(n));
    if (n > 512) return;
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_data_q.push_back(w);
      for (int k = 3; k >= 0; k--) begin
        stim_q.push_back(8'(w >> (8 * k)));
        cs = cs ^ 8'(w >> (8 * k));
      end
    end
    stim_q.push_back(corrupt ? (cs ^ 8'(($urandom_range(255, 1))))
                             : cs);
  endtask

  typedef struct {
    string        name;
    int           len;
    logic [127:0] s;
    int           gap;
    int           nw;
    logic [63:0]  w;
    bit           done;
    bit           err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0] basic[11];
    int         n;
    bit         corrupt;

    tbl[0] = '{"basic",    11, 128'h00028C2200040000_0001AB0000000000, 0, 2,
               64'h8C220004_00000001, 1'b1, 1'b0};
    tbl[1] = '{"empty",     3, 128'h0, 0, 0, 64'h0, 1'b1, 1'b0};
    tbl[2] = '{"oversize",  2, 128'h0201_0000_0000_0000_0000_0000_0000_0000, 0, 0,
               64'h0, 1'b0, 1'b1};
    tbl[3] = '{"badchk",   11, 128'h00028C2200040000_0001AC0000000000, 0, 2,
               64'h8C220004_00000001, 1'b0, 1'b1};
    tbl[4] = '{"stall",    11, 128'h00028C2200040000_0001AB0000000000, 3, 2,
               64'h8C220004_00000001, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) basic[i] = tbl[0].s[127-8*i -: 8];

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);
    check("idle_core_reset", 32'(bus.core_reset), 32'd1);

    for (int v = 0; v < 5; v++) begin
      stim_q.delete();
      exp_data_q.delete();
      for (int i = 0; i < tbl[v].len; i++) stim_q.push_back(tbl[v].s[127-8*i -: 8]);
      for (int i = 0; i < tbl[v].nw; i++) exp_data_q.push_back(tbl[v].w[63-32*i -: 32]);
      run_load(tbl[v].name, tbl[v].gap, 1'b0, tbl[v].done, tbl[v].err);
    end

    // Minimum-latency load: first write right after the 4th data byte, done 14 edges after start.
    begin
      int base;
      base = wea_cyc.size();
      stim_q.delete();
      exp_data_q.delete();
      for (int i = 0; i < 11; i++) stim_q.push_back(basic[i]);
      exp_data_q.push_back(32'h8C220004);
      exp_data_q.push_back(32'h00000001);
      run_load("timing", 0, 1'b0, 1'b1, 1'b0);
      if (wea_cyc.size() > base + 1) begin
        check("first_wea_latency", 32'(wea_cyc[base] - last_start), 32'd7);
        check("second_wea_latency", 32'(wea_cyc[base+1] - last_start), 32'd12);
      end else begin
        check("wea_seen", 32'(wea_cyc.size() - base), 32'd2);
      end
      check("done_latency", 32'(done_cyc - last_start), 32'd14);
    end

    // Asynchronous reset in the middle of a load
    do_start();
    for (int i = 0; i < 6; i++) send_byte(basic[i], 0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midload_reset");
    @(negedge clk);
    reset = 1'b0;
    stim_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < 11; i++) stim_q.push_back(basic[i]);
    exp_data_q.push_back(32'h8C220004);
    exp_data_q.push_back(32'h00000001);
    run_load("after_reset", 0, 1'b0, 1'b1, 1'b0);

    // Restart from DONE re-asserts core reset on the next edge
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_core_reset", 32'(bus.core_reset), 32'd1);
    check("restart_busy", 32'(bus.busy), 32'd1);
    check("restart_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 11; i++) send_byte(basic[i], 0);
    repeat (2) @(negedge clk);
    check("restart_final_done", 32'(bus.done), 32'd1);

    // Largest legal image fills every IMem word
    model_image(512, 1'b0);
    run_load("full_depth", 0, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(9, 0) == 0) n = int'($urandom_range(1000, 513));
      else n = int'($urandom_range(6, 0));
      corrupt = ($urandom_range(3, 0) == 0);
      model_image(n, corrupt);
      run_load($sformatf("rnd%0d_n%0d", r, n), 2, 1'b1,
               (n <= 512) && !corrupt, (n > 512) || corrupt);
    end

    check("wea_back_to_back", 32'(wea_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the processor's instruction memory, which the core only ever reads.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Writes them to consecutive word addresses through the IMem write port (wea/addra/dina).
- Holds the core in reset until a complete, checksum-verified image has been loaded.

Parameters:
- SIZE, 32, instruction word width in bits (fixed at 4 bytes).
- ADDR_W, 9, IMem word-address bits; depth DEPTH = 2**ADDR_W = 512 words.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load.
- in_valid  input  1  in_byte is valid this cycle.
- in_byte  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_wea  output  1  IMem write enable, one-cycle pulse per word.
- imem_addra  output  32  IMem word address, zero-extended from ADDR_W bits.
- imem_dina  output  32  assembled instruction word.
- core_reset  output  1  holds the processor in reset while high.
- busy  output  1  load in progress.
- done  output  1  last load succeeded; sticky until next start.
- error  output  1  last load failed; sticky until next start.

Behaviour:
- Reset is asynchronous and active-high. While asserted:
  - state=IDLE;
  - in_ready=0, imem_wea=0, imem_addra=0, imem_dina=0;
  - busy=0, done=0, error=0;
  - core_reset=1 (the core never runs on an unloaded image);
  - word counter, byte counter and checksum all 0.
- Stream format:
  - header: word count N, 16 bits, big-endian (2 bytes);
  - N×4 data bytes, each word MSB first;
  - one checksum byte = XOR of all data bytes (header bytes excluded).
- Handshake:
  - A byte transfers on a rising edge where in_valid & in_ready.
  - in_ready is a registered function of state: 1 in HDR_HI, HDR_LO, DATA, CHK; 0 otherwise.
  - in_valid may drop for any number of cycles with no effect on state.
- IDLE: on start, clear the counters, checksum and done/error; set busy=1 and core_reset=1; go to HDR_HI.
- HDR_HI: capture N[15:8]; go to HDR_LO.
- HDR_LO: capture N[7:0], then branch:
  - N > DEPTH → ERR;
  - N == 0 → CHK;
  - otherwise → DATA.
- DATA:
  - Shift each byte into the word register ({word[23:0], byte}) and XOR it into the checksum; byte counter 0..3.
  - On the 4th byte, go to WRITE.
- WRITE: exactly one cycle.
  - imem_wea=1, imem_addra=word index, imem_dina=assembled word. wea is asserted in the cycle after the 4th byte handshake.
  - Increment the word index, then go to CHK if index+1 == N, else to DATA.
- CHK: compare the received byte with the checksum.
  - Match → DONE.
  - Mismatch → ERR.
- DONE: busy=0, done=1, core_reset=0. A new start restarts the load (core_reset returns to 1 in the same cycle the state leaves DONE).
- ERR: busy=0, error=1, core_reset=1. A new start restarts the load.
- start outside IDLE/DONE/ERR is ignored.
- Address range: imem_addra covers 0..N-1; it never exceeds DEPTH-1, so no wrap-around occurs, because N > DEPTH is rejected in HDR_LO.
- Partial writes: words already written before an ERR remain in IMem; nothing is rolled back.
- Reset mid-load: the async reset aborts immediately and returns all outputs to their reset values. Any partially written IMem content is undefined and must be reloaded.
- Timing:
  - imem_wea never stays high for two consecutive cycles.
  - The minimum load time for N words is 2 + 5N + 1 cycles after start, plus 1 cycle for the IDLE→HDR_HI transition.

Test Plan:
- Basic load: start, then bytes 00 02 8C 22 00 04 00 00 00 01 AB with in_valid held high.
  - wea pulses at addr 0 with dina 0x8C220004, then at addr 1 with 0x00000001.
  - Then done=1, core_reset=0, error=0.
- Empty image: stream 00 00 00 → no wea pulse; done=1, core_reset=0.
- Oversize count: header 02 01 (N=513) → error=1 right after the second byte, in_ready=0, core_reset=1, no wea pulse.
- Bad checksum: basic stream with final byte 0xAC → both words written, then error=1, done=0, core_reset=1.
- Stalled source: basic stream with in_valid low for 3 cycles between every byte → identical wea/addr/dina sequence, and done=1.
- Reset and restart:
  - Assert reset after the 6th byte → all outputs at reset values immediately (asynchronous).
  - Afterwards start plus the full basic stream gives done=1.
  - A second start from DONE sets core_reset=1 and busy=1 on the next edge.
